bcd_display_scan: RTL and testbench
===================================

# bcd_display_scan

Time-multiplexed 7-segment display driver for a chain of cascaded BCD counter stages. Sits directly downstream of the BCD counters: it captures their packed digit outputs on a strobe, scans one digit at a time onto a shared segment bus, and flags any non-BCD digit. Output drives the board's common-anode display.

## Interface
- N_DIGITS, 4, number of BCD digits scanned (1..8); digit 0 is least significant.
- REFRESH_DIV, 1000, clock cycles each digit stays lit (>= 2).

- CLK  input  1  clock, positive-edge sensitive.
- Clear_b  input  1  asynchronous, active-low reset.
- Digits_in  input  4*N_DIGITS  packed BCD digits; digit k at bits [4k+3:4k].
- Latch  input  1  active high; capture Digits_in into snapshot register.
- Enable  input  1  active high; low blanks the display.
- Seg_out  output  7  segments {g,f,e,d,c,b,a}, active high, registered.
- Anode_out  output  N_DIGITS  digit select, active low, one-hot when lit, registered.
- Err_out  output  1  high while any snapshot digit > 9, registered.

One clock; reset is asynchronous and active-low.

## Operation
- Snapshot: on a CLK edge with Latch=1, snapshot <= Digits_in. Latch=0: snapshot holds. Display never reads Digits_in directly (no tearing mid-count).
- Refresh counter: 0..REFRESH_DIV-1, increments every cycle, wraps to 0.
- Scan index: 0..N_DIGITS-1; advances by 1 on the cycle refresh counter == REFRESH_DIV-1; wraps N_DIGITS-1 -> 0.
- Enable=0: refresh counter and scan index hold; Anode_out = all 1s, Seg_out = 0 from next edge. Enable=1 resumes from held state.
- Decode of snapshot digit at scan index (hex): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F; values A-F -> 40 (dash only).
- Anode_out bit [scan index] = 0, all others 1, when Enable=1.
- Err_out = OR over snapshot digits of (digit > 9).

## Timing
- Reset (Clear_b=0, asynchronous): snapshot = 0, refresh counter = 0, scan index = 0, Seg_out = 7'h00, Anode_out = all 1s, Err_out = 0.
- First edge after reset release with Enable=1: Anode_out = ...1110, Seg_out = 3F.
- Seg_out/Anode_out/Err_out are registered from scan index and snapshot: one cycle after either changes.
- Latch -> display: new value visible on Seg_out 2 edges after the Latch edge (snapshot edge + output edge).
- Each digit lit exactly REFRESH_DIV cycles; full frame = N_DIGITS*REFRESH_DIV cycles.
- Latch asserted every cycle: snapshot tracks Digits_in with one-cycle delay; legal.
- Latch coincident with scan advance: output uses the new index and the new snapshot one cycle later; no mixed state.
- Reset mid-scan: immediate return to reset values; scan restarts at digit 0.

## Configuration
- LEADING_ZERO_BLANK_EN defined: a digit k >= 1 is blanked (Seg_out = 00, anode still driven) when it and every more-significant snapshot digit equal 0. Digit 0 is never blanked. Non-BCD digits are never treated as zero.
- Not defined: all digits always decoded (zeros show 3F).

## Test plan
(N_DIGITS=4, REFRESH_DIV=4)
- Reset, Enable=1, no Latch -> Anode_out sequence 1110,1101,1011,0111 each held 4 cycles, Seg_out=3F throughout, Err_out=0.
- Digits_in=16'h1234, pulse Latch 1 cycle -> from 2 edges later, digit 0 shows 66, digit 1 4F, digit 2 5B, digit 3 06; Digits_in change without Latch leaves display unchanged.
- Digits_in=16'h00A5, Latch -> digit 1 shows 40, Err_out=1 one cycle after snapshot; relatch 16'h0095 -> Err_out=0.
- Enable low for 10 cycles mid-digit 2 -> Anode_out=1111, Seg_out=00; on re-enable digit 2 resumes with its remaining cycles.
- With LEADING_ZERO_BLANK_EN, snapshot 16'h0050 -> digits 3,2 Seg_out=00, digit 1 6D, digit 0 3F; snapshot 16'h0000 -> only digit 0 shows 3F.
- Assert Clear_b=0 asynchronously mid-frame -> all outputs at reset values without a clock edge; after release scan restarts at digit 0.

Source files
------------

// File: rtl/bcd_display_scan_if.sv
// Digit/segment bus between a BCD counter chain and the multiplexed display driver.
// Master side supplies digits and controls; slave side (the driver) returns display outputs.
interface bcd_display_scan_if #(
  parameter int unsigned N_DIGITS = 4
);
  logic [4*N_DIGITS-1:0] Digits_in;
  logic                  Latch;
  logic                  Enable;
  logic [6:0]            Seg_out;
  logic [N_DIGITS-1:0]   Anode_out;
  logic                  Err_out;

  modport master (
    output Digits_in, Latch, Enable,
    input  Seg_out, Anode_out, Err_out
  );

  modport slave (
    input  Digits_in, Latch, Enable,
    output Seg_out, Anode_out, Err_out
  );
endinterface

// File: rtl/bcd_display_scan.sv
// Time-multiplexed common-anode 7-segment driver for a snapshot of cascaded BCD digits.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 never blanked).
module bcd_display_scan #(
  parameter int unsigned N_DIGITS    = 4,
  parameter int unsigned REFRESH_DIV = 1000
) (
  input  logic CLK,
  input  logic Clear_b,
  bcd_display_scan_if.slave bus
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [4*N_DIGITS-1:0] snapshot;
  logic [CNT_W-1:0]      refresh_cnt;
  logic [IDX_W-1:0]      scan_idx;
  logic [6:0]            seg;
  logic [N_DIGITS-1:0]   anode;
  logic                  err;

  logic [3:0]            cur_digit;
  logic [6:0]            cur_seg;
  logic                  cur_blank;
  logic [N_DIGITS-1:0]   anode_next;
  logic                  err_next;

  always_comb begin
    cur_digit  = '0;
    anode_next = '1;
    err_next   = 1'b0;
    for (int unsigned k = 0; k < N_DIGITS; k++) begin
      if (scan_idx == IDX_W'(k)) begin
        cur_digit     = snapshot[4*k +: 4];
        anode_next[k] = 1'b0;
      end
      if (snapshot[4*k +: 4] > 4'd9) err_next = 1'b1;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [N_DIGITS-1:0] zero_above;

  // zero_above[k]: digit k and every more-significant digit are exactly zero
  always_comb begin
    zero_above = '0;
    for (int unsigned k = N_DIGITS; k > 0; k--) begin
      if (k == N_DIGITS)
        zero_above[k-1] = (snapshot[4*(k-1) +: 4] == 4'd0);
      else
        zero_above[k-1] = zero_above[k] && (snapshot[4*(k-1) +: 4] == 4'd0);
    end
    cur_blank = 1'b0;
    for (int unsigned k = 1; k < N_DIGITS; k++) begin
      if (scan_idx == IDX_W'(k)) cur_blank = zero_above[k];
    end
  end
`else
  assign cur_blank = 1'b0;
`endif

  always_comb begin
    case (cur_digit)
      4'd0:    cur_seg = 7'h3F;
      4'd1:    cur_seg = 7'h06;
      4'd2:    cur_seg = 7'h5B;
      4'd3:    cur_seg = 7'h4F;
      4'd4:    cur_seg = 7'h66;
      4'd5:    cur_seg = 7'h6D;
      4'd6:    cur_seg = 7'h7D;
      4'd7:    cur_seg = 7'h07;
      4'd8:    cur_seg = 7'h7F;
      4'd9:    cur_seg = 7'h6F;
      default: cur_seg = 7'h40;
    endcase
  end

  always_ff @(posedge CLK or negedge Clear_b) begin
    if (!Clear_b) begin
      snapshot    <= '0;
      refresh_cnt <= '0;
      scan_idx    <= '0;
      seg         <= '0;
      anode       <= '1;
      err         <= 1'b0;
    end else begin
      if (bus.Latch) snapshot <= bus.Digits_in;
      err <= err_next;
      if (bus.Enable) begin
        if (refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
          refresh_cnt <= '0;
          scan_idx    <= (scan_idx == IDX_W'(N_DIGITS - 1)) ? '0 : scan_idx + IDX_W'(1);
        end else begin
          refresh_cnt <= refresh_cnt + CNT_W'(1);
        end
        seg   <= cur_blank ? '0 : cur_seg;
        anode <= anode_next;
      end else begin
        seg   <= '0;
        anode <= '1;
      end
    end
  end

  assign bus.Seg_out   = seg;
  assign bus.Anode_out = anode;
  assign bus.Err_out   = err;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Randomized self-checking bench for bcd_display_scan (N_DIGITS=4, REFRESH_DIV=4) against
// a time-based reference: lit digit = (enabled cycles / REFRESH_DIV) mod N_DIGITS.
module tb_bcd_display_scan;

  localparam int unsigned N   = 4;
  localparam int unsigned DIV = 4;
  localparam logic [6:0] SEG_TAB [0:15] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40
  };

  logic clk = 1'b0;
  logic clear_b = 1'b0;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference state: snapshot and count of enabled edges since reset
  logic [15:0] m_snap = '0;
  int unsigned en_cycles = 0;

  bcd_display_scan_if #(.N_DIGITS(N)) bus ();

  bcd_display_scan #(.N_DIGITS(N), .REFRESH_DIV(DIV)) dut (
    .CLK     (clk),
    .Clear_b (clear_b),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_seg"},   32'(bus.Seg_out),   32'h00);
    check({tag, "_anode"}, 32'(bus.Anode_out), 32'hF);
    check({tag, "_err"},   32'(bus.Err_out),   32'h0);
  endtask

  // One clock: drive inputs, predict outputs from the pre-edge model, then compare.
  task automatic cycle(input logic l, input logic en, input logic [15:0] d);
    int unsigned idx;
    logic [3:0]  dig;
    logic [6:0]  e_seg;
    logic [3:0]  e_an;
    logic        e_err;
    logic        blank;
    bus.Latch     = l;
    bus.Enable    = en;
    bus.Digits_in = d;
    idx   = (en_cycles / DIV) % N;
    dig   = 4'((m_snap >> (4 * idx)) & 16'hF);
    blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    blank = (idx >= 1) && ((m_snap >> (4 * idx)) == 16'h0);
`endif
    e_err = 1'b0;
    for (int k = 0; k < int'(N); k++)
      if (((m_snap >> (4 * k)) & 16'hF) > 16'd9) e_err = 1'b1;
    e_seg = en ? (blank ? 7'h00 : SEG_TAB[dig]) : 7'h00;
    e_an  = en ? ~(4'b0001 << idx) : 4'hF;
    if (l) m_snap = d;
    if (en) en_cycles++;
    @(posedge clk);
    #1;
    check("seg",   32'(bus.Seg_out),   32'(e_seg));
    check("anode", 32'(bus.Anode_out), 32'(e_an));
    check("err",   32'(bus.Err_out),   32'(e_err));
  endtask

  task automatic run(input int unsigned n, input logic en, input logic [15:0] d);
    for (int i = 0; i < int'(n); i++) cycle(1'b0, en, d);
  endtask

  initial begin
    logic [15:0] rd;
    bus.Latch = 1'b0;
    bus.Enable = 1'b0;
    bus.Digits_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    clear_b = 1'b1;

    run(16, 1'b1, 16'h0000);
    cycle(1'b1, 1'b1, 16'h1234);
    run(16, 1'b1, 16'h9999);
    cycle(1'b1, 1'b1, 16'h00A5);
    run(16, 1'b1, 16'h00A5);
    cycle(1'b1, 1'b1, 16'h0095);
    run(10, 1'b1, 16'h0095);
    run(10, 1'b0, 16'h0095);
    run(16, 1'b1, 16'h0095);
    cycle(1'b1, 1'b1, 16'h0050);
    run(16, 1'b1, 16'h0000);
    cycle(1'b1, 1'b1, 16'h0000);
    run(16, 1'b1, 16'h7777);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 16'(16'h1111 * i));

    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < int'(N); k++)
        rd[4*k +: 4] = ($urandom % 3 == 0) ? 4'h0 : 4'($urandom % 16);
      cycle(($urandom % 4) == 0, ($urandom % 8) != 0, rd);
    end

    run(6, 1'b1, 16'h0000);
    #2;
    clear_b = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    m_snap = '0;
    en_cycles = 0;
    @(posedge clk);
    #1;
    check_reset_outputs("held_reset");
    clear_b = 1'b1;
    run(20, 1'b1, 16'h4321);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d", n_pass, n_checks);
    $fatal(1, "timeout");
  end

endmodule
